vga_layer_sched: RTL and testbench

Pixel-timing and layer scheduler for the 800x600 VGA shader pipeline.
- Derives the pixel tick from the system clock and runs the h/v counters and sync outputs.
- Publishes centred x/y coordinates and a per-frame animation timer to the shader layers.
- Each pixel, arbitrates the shared 8-bit RGB output between NUM_LAYERS shader requesters.
- Accepts runtime configuration through a valid/ready handshake and commits it only at frame boundaries, so there is no mid-frame tearing.

---
 rtl/vga_layer_sched.sv | 196 +++++++++++++++++++
 tb/tb_vga_layer_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_sched.sv
// VGA pixel timing, per-pixel layer arbitration and frame-synchronous runtime configuration.
// Define SCHED_STATS_EN to build the per-frame background-underflow counter.
module vga_layer_sched #(
  parameter int          NUM_LAYERS   = 2,
  parameter int          PIX_DIV      = 3,
  parameter int          H_ACTIVE     = 800,
  parameter int          H_SYNC_START = 840,
  parameter int          H_SYNC_END   = 968,
  parameter int          H_TOTAL      = 1056,
  parameter int          V_ACTIVE     = 600,
  parameter int          V_SYNC_START = 601,
  parameter int          V_SYNC_END   = 605,
  parameter int          V_TOTAL      = 628,
  parameter logic [7:0]  BG_COLOR     = 8'h02
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    pix_en,
  output logic                    frame_start,
  output logic [11:0]             hcount,
  output logic [11:0]             vcount,
  output logic [11:0]             x,
  output logic [11:0]             y,
  output logic [7:0]              timer,
  input  logic [NUM_LAYERS-1:0]   layer_valid,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [11:0]             cfg_data,
  output logic [2:0]              red_F,
  output logic [2:0]              green_F,
  output logic [1:0]              blue_F,
  output logic                    hsync,
  output logic                    vsync,
  output logic [19:0]             underflow_cnt
);

  localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

  logic [3:0]  div_q;
  logic        pixEn_q;
  logic        frameStart_q;
  logic [11:0] hCount_q;
  logic [11:0] vCount_q;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic        hSync_q;
  logic        vSync_q;
  logic [7:0]  rgb_q;
  logic [7:0]  timer_q;
  logic [3:0]  mask_q;
  logic [7:0]  step_q;
  logic [3:0]  pendMask_q;
  logic [7:0]  pendStep_q;
  logic        pendValid_q;

  logic        lineEnd;
  logic        frameEnd;
  logic        activeRegion;
  logic [7:0]  pixColor_d;
  logic        unusedMaskBits;

  assign lineEnd      = (hCount_q == H_LAST);
  assign frameEnd     = lineEnd && (vCount_q == V_LAST);
  assign activeRegion = (hCount_q < 12'(H_ACTIVE)) && (vCount_q < 12'(V_ACTIVE));

  // Mask bits for layers that do not exist are stored but never consulted.
  assign unusedMaskBits = ^mask_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      pixEn_q      <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      div_q        <= (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      pixEn_q      <= (div_q == DIV_LAST);
      frameStart_q <= (div_q == DIV_LAST) && (hCount_q == 12'd0) && (vCount_q == 12'd0);
    end
  end

  // Scanning downward leaves the lowest-index qualifying layer as the winner.
  always_comb begin
    pixColor_d = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i] && mask_q[i]) begin
        pixColor_d = layer_rgb[8*i +: 8];
      end
    end
    if (!activeRegion) begin
      pixColor_d = 8'h00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hCount_q <= '0;
      vCount_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hSync_q  <= 1'b1;
      vSync_q  <= 1'b1;
      rgb_q    <= '0;
    end else if (pixEn_q) begin
      if (lineEnd) begin
        hCount_q <= '0;
        vCount_q <= (vCount_q == V_LAST) ? 12'd0 : vCount_q + 12'd1;
      end else begin
        hCount_q <= hCount_q + 12'd1;
      end
      hSync_q <= !((hCount_q >= 12'(H_SYNC_START)) && (hCount_q < 12'(H_SYNC_END)));
      vSync_q <= !((vCount_q >= 12'(V_SYNC_START)) && (vCount_q < 12'(V_SYNC_END)));
      x_q     <= hCount_q - 12'(H_ACTIVE / 2);
      y_q     <= vCount_q - 12'(V_ACTIVE / 2);
      rgb_q   <= pixColor_d;
    end
  end

  // A pending config is only committed if it was captured before the boundary clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q     <= '0;
      mask_q      <= 4'hF;
      step_q      <= 8'd1;
      pendMask_q  <= '0;
      pendStep_q  <= '0;
      pendValid_q <= 1'b0;
    end else begin
      if (pixEn_q && frameEnd) begin
        timer_q <= timer_q + step_q;
        if (pendValid_q) begin
          mask_q <= pendMask_q;
          step_q <= pendStep_q;
        end
      end
      if (cfg_valid && !pendValid_q) begin
        pendValid_q <= 1'b1;
        pendMask_q  <= cfg_data[11:8];
        pendStep_q  <= cfg_data[7:0];
      end else if (pixEn_q && frameEnd) begin
        pendValid_q <= 1'b0;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [19:0] bgCount_q;
  logic [19:0] bgCount_d;
  logic [19:0] underflow_q;
  logic        bgSelected;

  assign bgSelected = activeRegion && ((layer_valid & mask_q[NUM_LAYERS-1:0]) == '0);

  always_comb begin
    bgCount_d = bgCount_q;
    if (bgSelected && (bgCount_q != 20'hFFFFF)) begin
      bgCount_d = bgCount_q + 20'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bgCount_q   <= '0;
      underflow_q <= '0;
    end else if (pixEn_q) begin
      if (frameEnd) begin
        underflow_q <= bgCount_d;
        bgCount_q   <= '0;
      end else begin
        bgCount_q <= bgCount_d;
      end
    end
  end

  assign underflow_cnt = underflow_q;
`else
  assign underflow_cnt = 20'd0;
`endif

  assign pix_en      = pixEn_q;
  assign frame_start = frameStart_q;
  assign hcount      = hCount_q;
  assign vcount      = vCount_q;
  assign x           = x_q;
  assign y           = y_q;
  assign timer       = timer_q;
  assign cfg_ready   = !pendValid_q;
  assign red_F       = rgb_q[7:5];
  assign green_F     = rgb_q[4:2];
  assign blue_F      = rgb_q[1:0];
  assign hsync       = hSync_q;
  assign vsync       = vSync_q;

endmodule

// File: tb/tb_vga_layer_sched.sv
// Scoreboard bench for vga_layer_sched on a shrunken raster; a pixel-index reference model predicts every output.
// Build with SCHED_STATS_EN defined to also predict underflow_cnt.
`timescale 1ns/1ps
module tb_vga_layer_sched;

  localparam int NL    = 2;
  localparam int PD    = 3;
  localparam int HA    = 16;
  localparam int HSS   = 18;
  localparam int HSE   = 21;
  localparam int HT    = 24;
  localparam int VA    = 8;
  localparam int VSS   = 9;
  localparam int VSE   = 11;
  localparam int VT    = 12;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] BG = 8'h02;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            pix_en, frame_start, cfg_ready, hsync, vsync;
  logic [11:0]     hcount, vcount, x, y;
  logic [7:0]      timer;
  logic [NL-1:0]   layer_valid;
  logic [8*NL-1:0] layer_rgb;
  logic            cfg_valid;
  logic [11:0]     cfg_data;
  logic [2:0]      red_F, green_F;
  logic [1:0]      blue_F;
  logic [19:0]     underflow_cnt;

  typedef struct packed {
    logic [7:0]  rgb;
    logic        hs;
    logic        vs;
    logic [11:0] px;
    logic [11:0] py;
  } pix_t;

  pix_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b1;

  vga_layer_sched #(
    .NUM_LAYERS(NL), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .BG_COLOR(BG)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en), .frame_start(frame_start),
    .hcount(hcount), .vcount(vcount), .x(x), .y(y), .timer(timer),
    .layer_valid(layer_valid), .layer_rgb(layer_rgb),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .red_F(red_F), .green_F(green_F), .blue_F(blue_F),
    .hsync(hsync), .vsync(vsync), .underflow_cnt(underflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NL-1:0] lv, input logic [8*NL-1:0] lr,
                               input logic cv, input logic [11:0] cd);
    layer_valid = lv;
    layer_rgb   = lr;
    cfg_valid   = cv;
    cfg_data    = cd;
  endtask

  task automatic checkResetState();
    checkOutput("rst_hcount", hcount, 0);
    checkOutput("rst_vcount", vcount, 0);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_timer", timer, 0);
    checkOutput("rst_rgb", {red_F, green_F, blue_F}, 0);
    checkOutput("rst_hsync", hsync, 1);
    checkOutput("rst_vsync", vsync, 1);
    checkOutput("rst_pix_en", pix_en, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_underflow", underflow_cnt, 0);
  endtask

  // Reference colour: first enabled valid layer wins inside the visible window.
  function automatic logic [7:0] refPixel(input int h, input int v, input logic [NL-1:0] lv,
                                          input logic [8*NL-1:0] lr, input logic [3:0] mask);
    if (h >= HA || v >= VA) return 8'h00;
    for (int i = 0; i < NL; i++) begin
      if (lv[i] && mask[i]) return lr[8*i +: 8];
    end
    return BG;
  endfunction

  // Monitor: registered pixel outputs settle on the edge that drops pix_en.
  initial begin
    pix_t e;
    forever begin
      @(negedge pix_en);
      #1;
      if (reset_n && running) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underrun: got pixel output with empty scoreboard at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("rgb", {red_F, green_F, blue_F}, e.rgb);
          checkOutput("hsync", hsync, e.hs);
          checkOutput("vsync", vsync, e.vs);
          checkOutput("x", x, e.px);
          checkOutput("y", y, e.py);
        end
      end
    end
  end

  // Driver and reference model, stepped on every falling clock edge.
  initial begin
    int cyc, p, h, v, frm, mode, xi, yi, mBg, mUnder;
    logic [7:0] mTimer, mStep, pStep;
    logic [3:0] mMask, pMask;
    logic mPend, expPix, readyBefore, cv, didReset;
    logic [11:0] cd;
    logic [NL-1:0] lv;
    logic [8*NL-1:0] lr;
    pix_t e;

    didReset = 1'b0;
    applyStimulus('0, '0, 1'b0, 12'h000);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkResetState();
    mTimer = 8'd0; mStep = 8'd1; mMask = 4'hF; mPend = 1'b0;
    pStep = 8'd0; pMask = 4'h0; mBg = 0; mUnder = 0;
    reset_n = 1'b1;
    cyc = 0;
    p = 0;

    while (!(didReset && p >= 5 * FRAME)) begin
      @(negedge clock);
      cyc++;
      expPix = ((cyc % PD) == 0);
      h = p % HT;
      v = (p / HT) % VT;
      frm = p / FRAME;

      checkOutput("pix_en", pix_en, expPix);
      checkOutput("frame_start", frame_start, expPix && ((p % FRAME) == 0));
      checkOutput("cfg_ready", cfg_ready, !mPend);
      checkOutput("timer", timer, mTimer);
      checkOutput("underflow_cnt", underflow_cnt, mUnder);
      if (expPix) begin
        checkOutput("hcount", hcount, h);
        checkOutput("vcount", vcount, v);
      end

      // Mid-line reset while a config is still waiting for its frame boundary.
      if (!didReset && expPix && frm == 5 && v == 2 && h == HA / 2) begin
        reset_n = 1'b0;
        applyStimulus('0, '0, 1'b0, 12'h000);
        #1;
        checkResetState();
        sb.delete();
        mTimer = 8'd0; mStep = 8'd1; mMask = 4'hF; mPend = 1'b0; mBg = 0; mUnder = 0;
        didReset = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        p = 0;
        continue;
      end

      cv = 1'b0;
      cd = 12'($urandom);
      if (!didReset && expPix && frm == 1 && v == 1 && h == 5) begin
        cv = 1'b1; cd = {4'b0010, 8'd5};
      end
      if (!didReset && expPix && frm == 3 && (p % FRAME) == FRAME - 1) begin
        cv = 1'b1; cd = {4'b0001, 8'd7};
      end
      if (!didReset && expPix && frm == 5 && v == 0 && h == 3) begin
        cv = 1'b1; cd = {4'b0011, 8'd9};
      end
      if (didReset && $urandom_range(0, 149) == 0) begin
        cv = 1'b1;
      end
      readyBefore = !mPend;

      lv = NL'($urandom);
      for (int i = 0; i < NL; i++) lr[8*i +: 8] = 8'($urandom);

      if (expPix) begin
        mode = frm % 3;
        if (mode == 1) lv = '0;
        if (mode == 2) lv = '1;
        e.rgb = refPixel(h, v, lv, lr, mMask);
        e.hs  = !(h >= HSS && h < HSE);
        e.vs  = !(v >= VSS && v < VSE);
        xi = h - HA / 2;
        yi = v - VA / 2;
        if (xi < 0) xi += 4096;
        if (yi < 0) yi += 4096;
        e.px = 12'(xi);
        e.py = 12'(yi);
        sb.push_back(e);
        if (h < HA && v < VA && (lv & mMask[NL-1:0]) == '0) mBg++;
        if ((p % FRAME) == FRAME - 1) begin
`ifdef SCHED_STATS_EN
          mUnder = (mBg > 20'hFFFFF) ? 20'hFFFFF : mBg;
`endif
          mBg = 0;
          mTimer = mTimer + mStep;
          if (mPend) begin
            mMask = pMask;
            mStep = pStep;
            mPend = 1'b0;
          end
        end
        p++;
      end

      if (cv && readyBefore) begin
        mPend = 1'b1;
        pMask = cd[11:8];
        pStep = cd[7:0];
      end
      applyStimulus(lv, lr, cv, cd);
    end

    applyStimulus('0, '0, 1'b0, 12'h000);
    @(posedge clock);
    #2;
    checkOutput("sb_drain", sb.size(), 0);
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
